// File: rtl/reduce_tree_pipe.sv
// Pipelined N-input bitwise reduction tree (AND/OR/XOR/NAND per beat) with a
// single global advance enable shared by every stage and valid/ready on both sides.
module reduce_tree_pipe #(
  parameter int N_INPUTS   = 16,
  parameter int WIDTH      = 1,
  parameter int PIPE_EVERY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_INPUTS*WIDTH-1:0] a,
  input  logic [1:0]                op,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          f,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int PE         = (PIPE_EVERY < 1) ? 1 : PIPE_EVERY;
  localparam int LEVELS     = $clog2(N_INPUTS);
  localparam int STAGES_RAW = (LEVELS + PE - 1) / PE;
  localparam int STAGES     = (STAGES_RAW < 1) ? 1 : STAGES_RAW;

  if (N_INPUTS < 2 || (N_INPUTS & (N_INPUTS - 1)) != 0 || WIDTH < 1 || PIPE_EVERY < 1) begin : g_param_err
    $error("reduce_tree_pipe: N_INPUTS must be a power of two >= 2, WIDTH and PIPE_EVERY >= 1");
  end

  // Last tree level completed by the end of stage s.
  function automatic int lvl_hi(input int s);
    return ((s + 1) * PE < LEVELS) ? (s + 1) * PE : LEVELS;
  endfunction

  // NAND shares the AND tree; the inversion happens only at the output.
  function automatic logic [WIDTH-1:0] combine(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (sel)
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return x & y;
    endcase
  endfunction

  logic [STAGES-1:0] valid_reg;
  logic              adv;
  logic              accept;

  assign out_valid = valid_reg[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign busy      = |valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (adv) begin
      valid_reg[0] <= accept;
      for (int s = 1; s < STAGES; s++) begin
        valid_reg[s] <= valid_reg[s-1];
      end
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
    localparam int LO    = gi * PE;
    localparam int HI    = lvl_hi(gi);
    localparam int D     = HI - LO;
    localparam int NIN   = N_INPUTS >> LO;
    localparam int NOUT  = N_INPUTS >> HI;
    localparam int NODES = 2 * NIN - NOUT;

    logic [NIN*WIDTH-1:0]   d_in;
    logic [1:0]             op_in;
    // All levels of this stage packed level after level, operand-granular.
    logic [NODES*WIDTH-1:0] node;
    logic [NOUT*WIDTH-1:0]  data_q;
    logic [1:0]             op_q;

    if (gi == 0) begin : g_src
      assign d_in  = a;
      assign op_in = op;
    end else begin : g_src
      assign d_in  = gen_stage[gi-1].data_q;
      assign op_in = gen_stage[gi-1].op_q;
    end

    assign node[NIN*WIDTH-1:0] = d_in;

    for (genvar gj = 1; gj <= D; gj++) begin : gen_lvl
      localparam int SRC = 2 * NIN - 2 * (NIN >> (gj - 1));
      localparam int DST = 2 * NIN - 2 * (NIN >> gj);
      for (genvar gk = 0; gk < (NIN >> gj); gk++) begin : gen_node
        assign node[(DST+gk)*WIDTH +: WIDTH] =
          combine(op_in, node[(SRC+2*gk)*WIDTH +: WIDTH], node[(SRC+2*gk+1)*WIDTH +: WIDTH]);
      end
    end

    if (gi == STAGES - 1) begin : g_reg
      // Output register: cleared on reset so f reads 0 (AND of zero data).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          op_q   <= 2'b00;
        end else if (adv) begin
          data_q <= node[NODES*WIDTH-1 -: NOUT*WIDTH];
          op_q   <= op_in;
        end
      end
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (adv) begin
          data_q <= node[NODES*WIDTH-1 -: NOUT*WIDTH];
          op_q   <= op_in;
        end
      end
    end
  end

  assign f = (gen_stage[STAGES-1].op_q == 2'b11) ? ~gen_stage[STAGES-1].data_q
                                                 :  gen_stage[STAGES-1].data_q;

endmodule

// File: doc/reduce_tree_pipe.md
Name: reduce_tree_pipe

Overview:
- Parametrised, pipelined N-input bitwise reduction tree; the successor to the fixed 4-input AND-of-2-input-gates structure.
- Reduces N_INPUTS operands of WIDTH bits each to one WIDTH-bit result.
- Operation is selectable per beat: AND, OR, XOR or NAND.
- Registers are inserted every PIPE_EVERY tree levels; valid/ready handshake on both sides with backpressure.

Parameters:
- N_INPUTS, 16, number of operands; power of two, >= 2.
- WIDTH, 1, bits per operand; >= 1.
- PIPE_EVERY, 1, tree levels per pipeline stage; >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- a  in  N_INPUTS*WIDTH  packed operands; operand i = a[i*WIDTH +: WIDTH].
- op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- in_valid  in  1  a/op valid.
- in_ready  out  1  block accepts beat this cycle.
- f  out  WIDTH  reduction result.
- out_valid  out  1  f valid.
- out_ready  in  1  consumer accepts f.
- busy  out  1  any valid beat held in the pipe.

Behaviour:
- Derived values: LEVELS = log2(N_INPUTS); STAGES = ceil(LEVELS/PIPE_EVERY), minimum 1. The last stage is the output register driving f/out_valid.
- Tree structure: level k combines adjacent pairs from level k-1, bitwise per lane. AND/NAND use the AND tree; NAND inverts only at the final stage. OR uses the OR tree. XOR uses the XOR tree.
- op is captured with the beat and travels down the pipe with its data. Each beat uses its own op; changing op between beats is legal.
- Stall rule: global advance enable adv = !out_valid || out_ready, and in_ready = adv (combinational).
  - All stages shift only when adv=1.
  - A bubble in an earlier stage does not let the pipe advance while the output is stalled.
- Accept: beat accepted on an edge with in_valid && in_ready.
  - in_valid with in_ready=0 is ignored; the source must hold a/op/in_valid until accepted.
- Latency: a beat accepted at edge t shows out_valid=1 with its f after edge t+STAGES-1, given no stall. With STAGES=1 it is visible immediately after the acceptance edge.
- Throughput: one beat per cycle while out_ready=1.
- Hold: while out_valid && !out_ready, f and out_valid stay constant and no internal stage changes.
- Ordering: results leave in acceptance order; no loss, no duplication.
- Per-stage valid bits:
  - A stage's valid loads the upstream valid when adv=1.
  - Stage 1 loads in_valid && in_ready.
  - busy = OR of all stage valid bits.
- Reset: rst_n low clears all stage valid bits, out_valid, f (to 0) and busy asynchronously. Internal data registers need no reset.
- After reset release: in_ready=1, and the first beat is accepted on the first edge with in_valid=1.
- Reset mid-stream: in-flight beats are discarded, and no stale result appears after release.
- Edge parameters:
  - N_INPUTS=2 gives one level and one stage.
  - PIPE_EVERY >= LEVELS gives a single stage, with the whole tree combinational before the output register.
- Out-of-range parameters are a configuration error (elaboration-time assertion).

Test Plan:
- Reset, N=16 WIDTH=4 PIPE_EVERY=2 (STAGES=2): hold rst_n=0 -> out_valid=0, f=4'h0, busy=0, in_ready=1. Release rst_n -> the same values until a beat is accepted.
- Single AND beat: all operands 4'hF except operand 7 = 4'hE, op=00, out_ready=1 -> out_valid=1 with f=4'hE after the second edge following acceptance. Then out_valid=0 and busy=0.
- Streamed beats, one per cycle, out_ready=1 -> results on consecutive cycles in order, each with its own op:
  - OR with operand 3 = 4'h8, rest 0 -> 4'h8.
  - XOR with operand i = i -> 4'h0.
  - NAND with all 4'hF -> 4'h0.
  - AND with all 4'hA -> 4'hA.
- Backpressure: out_ready=0 for 5 cycles while the source offers 3 beats.
  - Two beats are accepted, then in_ready=0.
  - f is stable across the stall.
  - Raising out_ready drains all 3 results in order, with no duplicates.
- Reset mid-stream: pull rst_n low with 2 beats in flight -> out_valid and busy drop without waiting for an edge. After release, no output appears until a new beat is accepted.
- Parameter sweep:
  - N=2 WIDTH=1 PIPE_EVERY=1: latency 1, a=2'b10 op=00 -> f=0.
  - N=32 WIDTH=1 PIPE_EVERY=3 (STAGES=2): all ones, op=11 -> f=0, latency 2.
  - N=8 WIDTH=8 PIPE_EVERY=1 (STAGES=3): random operands vs. a reference model over 1000 beats with random out_ready.
